// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiply / restoring divide (MUL AB, DIV AB), one bit per cycle.
// Signed operation is compiled in only when MULDIV_SIGNED_EN is defined.
module alu_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sel,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_in_1,
    input  logic [WIDTH-1:0] op_in_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] op_out_1,
    output logic [WIDTH-1:0] op_out_2,
    output logic             overflow_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   oper_q, oper_d;
    logic               op_q, op_d;
    logic               sgn_q, sgn_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   res1_q, res1_d;
    logic [WIDTH-1:0]   res2_q, res2_d;
    logic               ov_q, ov_d;

    logic sgn_in;
`ifdef MULDIV_SIGNED_EN
    assign sgn_in = signed_mode;
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign sgn_in = 1'b0;
`endif

    // The datapath always runs on magnitudes; signs are restored when the result is registered.
    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = (sgn_in && op_in_1[WIDTH-1]) ? -op_in_1 : op_in_1;
    assign mag_b = (sgn_in && op_in_2[WIDTH-1]) ? -op_in_2 : op_in_2;

    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge  = (rem_sh >= {1'b0, oper_q});
        rem_sub = div_ge ? WIDTH'(rem_sh - {1'b0, oper_q}) : rem_sh[WIDTH-1:0];
        if (op_q) begin
            acc_step = {rem_sub, acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    logic               neg_res;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        neg_res = sgn_q && (neg_a_q ^ neg_b_q);
        prod    = neg_res ? -acc_step : acc_step;
        quot    = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem     = (sgn_q && neg_a_q) ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        oper_d  = oper_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        ov_d    = ov_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op_sel;
                    if (op_sel && (op_in_2 == '0)) begin
                        state_d = ST_DONE;
                        sgn_d   = 1'b0;
                        res1_d  = '1;
                        res2_d  = op_in_1;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        sgn_d   = sgn_in;
                        neg_a_d = sgn_in && op_in_1[WIDTH-1];
                        neg_b_d = sgn_in && op_in_2[WIDTH-1];
                        if (op_sel) begin
                            acc_d  = {{WIDTH{1'b0}}, mag_a};
                            oper_d = mag_b;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, mag_b};
                            oper_d = mag_a;
                        end
                    end
                end
            end
            ST_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    if (op_q) begin
                        res1_d = quot;
                        res2_d = rem;
                        // Only MIN / -1 yields a positive quotient magnitude with the MSB set.
                        ov_d   = sgn_q && !neg_res && acc_step[WIDTH-1];
                    end else begin
                        res1_d = prod[WIDTH-1:0];
                        res2_d = prod[2*WIDTH-1:WIDTH];
                        ov_d   = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                       : (prod[2*WIDTH-1:WIDTH] != '0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            oper_q  <= '0;
            op_q    <= 1'b0;
            sgn_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            res1_q  <= '0;
            res2_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            oper_q  <= oper_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            ov_q    <= ov_d;
        end
    end

    assign busy         = (state_q == ST_BUSY);
    assign done         = (state_q == ST_DONE);
    assign op_out_1     = res1_q;
    assign op_out_2     = res2_q;
    assign overflow_out = ov_q;
    assign carry_out    = 1'b0;

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide unit for the 8051 datapath; it implements MUL AB and DIV AB for any operand width. It sits beside `alu_core`. The control unit launches an operation with a one-cycle `start` pulse and reads the results when `done` pulses. Results go to A/B, and overflow/carry go to the `psw` flag inputs. Iterative shift-add multiply and restoring divide, one bit per cycle, with the 8051 flag rules extended to WIDTH bits and an optional signed mode.

## Interface
- `WIDTH`, 8, operand width in bits; legal range 4..32.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset (reset = 0 clears all state).
- `start`  in  1  one-cycle launch request; sampled only in IDLE.
- `op_sel`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `signed_mode`  in  1  two's-complement operands; sampled with `start`; effective only with `MULDIV_SIGNED_EN`.
- `op_in_1`  in  WIDTH  A operand: multiplicand or dividend.
- `op_in_2`  in  WIDTH  B operand: multiplier or divisor.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when the results are valid.
- `op_out_1`  out  WIDTH  product low half, or quotient (goes to A).
- `op_out_2`  out  WIDTH  product high half, or remainder (goes to B).
- `overflow_out`  out  1  OV flag for the `psw`.
- `carry_out`  out  1  CY flag; always 0.

## Operation
- **States:**
  - IDLE: waits for a start.
  - BUSY: runs WIDTH iterations using a log2(WIDTH)+1-bit counter.
  - DONE: holds for one cycle.
- **IDLE → BUSY** on `start`=1. Operands, `op_sel` and `signed_mode` are latched, and the counter is cleared.
- **BUSY, multiply:** each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of the 2·WIDTH accumulator, then shift the accumulator right 1.
- **BUSY, divide:** each cycle, shift the remainder left, bringing in the next dividend bit from the MSB down. Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1.
- **BUSY → DONE** after WIDTH iterations. The results and flags are registered on this transition.
- **DONE → IDLE** unconditionally. `op_out_1`, `op_out_2` and `overflow_out` hold their values until the next completion.
- **Multiply flags:** `overflow_out` = 1 if and only if the product does not fit in WIDTH bits. Unsigned: `op_out_2` ≠ 0. Signed: the high half is not a sign extension of `op_out_1[WIDTH-1]`.
- **Divide-by-zero** (`op_in_2` = 0 with `op_sel` = 1):
  - IDLE goes directly to DONE, skipping BUSY.
  - `op_out_1` = all-ones, `op_out_2` = the dividend, `overflow_out` = 1.
- **Divide, normal:** `overflow_out` = 0.
- `start` in BUSY or DONE is ignored. It is not queued.
- Reset asserted mid-operation aborts the operation immediately. All state and outputs return to their reset values.

## Timing
- **Reset values:** state = IDLE; `busy`, `done`, `op_out_1`, `op_out_2`, `overflow_out` and `carry_out` are all 0.
- **Normal operation:** start is sampled at edge 0. `busy` is 1 from edge 1 through edge WIDTH. `done` = 1 for exactly one cycle after edge WIDTH+1. Results are valid in that same cycle.
- **Latency:** start to `done` is WIDTH+1 cycles; 9 cycles for WIDTH = 8.
- **Divide-by-zero:** `done` rises after edge 1; `busy` never asserts.
- **Back-to-back:** the earliest following start is accepted in the cycle after `done`.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - When `signed_mode` = 1, the block computes on operand magnitudes and corrects signs on the way into DONE; latency is unchanged.
  - Product sign = sign(A) XOR sign(B).
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / −1 gives `op_out_1` = MIN, `op_out_2` = 0, `overflow_out` = 1.
- `MULDIV_SIGNED_EN` undefined:
  - `signed_mode` is ignored and all operations are unsigned.
  - The port remains, so instantiations are unchanged.

## Test plan
- **Unsigned multiply** (WIDTH = 8, MUL 0x50 × 0xA0) → after 9 cycles `done` = 1; `op_out_1` = 0x00, `op_out_2` = 0x32, `overflow_out` = 1, `carry_out` = 0. `busy` is high for cycles 1–8.
- **Unsigned divide** (DIV 0xFB / 0x12) → `op_out_1` = 0x0D, `op_out_2` = 0x11, `overflow_out` = 0, `done` at cycle 9. Then MUL 0x0C × 0x10 → 0xC0 / 0x00, `overflow_out` = 0.
- **Divide-by-zero** (DIV 0x55 / 0x00) → `done` at cycle 1, `busy` never high; `op_out_1` = 0xFF, `op_out_2` = 0x55, `overflow_out` = 1.
- **Start ignored while busy:** start MUL 0x03 × 0x04, then pulse start with DIV 0x10 / 0x02 at cycle 4 → the single `done` comes at cycle 9 with 0x0C / 0x00. No second `done` follows.
- **Reset mid-operation:** assert `reset` = 0 at cycle 5 of a divide → all outputs are 0 immediately. After release, a new MUL 0xFF × 0xFF gives 0x01 / 0xFE with `overflow_out` = 1.
- **Signed, with `MULDIV_SIGNED_EN`:**
  - MUL 0xFA × 0x07 → 0xD6 / 0xFF, `overflow_out` = 0.
  - DIV 0xF9 / 0x02 → 0xFD / 0xFF.
  - DIV 0x80 / 0xFF → 0x80 / 0x00, `overflow_out` = 1.
